// File: rtl/wlo_pkg.sv
// Shared types and defaults for the word-length-optimisation sweep scheduler.
package wlo_pkg;

   localparam int         DEF_NUM_CHAN = 15;
   localparam int         DEF_WL_W     = 8;
   localparam int         DEF_MSE_W    = 64;
   localparam logic [7:0] DEF_FRAC     = 8'd16;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      FLUSH,
      MEASURE,
      DECIDE,
      NEXT,
      DONE
   } state_t;

   typedef logic [DEF_NUM_CHAN-1:0][DEF_WL_W-1:0] frac_vec_t;

   // Measurement counter holds at all-ones rather than wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/wlo_cycle_timer.sv
// Loadable down-counter with a zero flag; shared by the flush length and the watchdog.
module wlo_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   // A load wins over counting; counting stops at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/wlo_sweep_scheduler.sv
// Greedy per-channel word-length sweep: lower one bit, flush, measure, keep or restore.
// Optional measurement watchdog is built when WLO_TIMEOUT_EN is defined.
module wlo_sweep_scheduler
   import wlo_pkg::*;
#(
   parameter int NUM_CHAN    = DEF_NUM_CHAN,
   parameter int WL_W        = DEF_WL_W,
   parameter int FLUSH_CYC   = 32,
   parameter int MSE_W       = DEF_MSE_W,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               go_i,
   input  logic [WL_W-1:0]                    init_frac_i,
   input  logic [WL_W-1:0]                    min_frac_i,
   input  logic [MSE_W-1:0]                   mse_threshold_i,
   input  logic [MSE_W-1:0]                   mse_data_i,
   input  logic                               mse_valid_i,
   output logic [NUM_CHAN-1:0][WL_W-1:0]      frac_wl_o,
   output logic                               dp_flush_o,
   output logic                               meas_start_o,
   output logic [$clog2(NUM_CHAN)-1:0]        chan_idx_o,
   output logic [15:0]                        eval_count_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o
);

   localparam int CW   = $clog2(NUM_CHAN);
   localparam int TMAX = (FLUSH_CYC > TIMEOUT_CYC) ? FLUSH_CYC : TIMEOUT_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   state_t                        state_q;
   logic [NUM_CHAN-1:0][WL_W-1:0] frac_q;
   logic [WL_W-1:0]               min_frac_q;
   logic [MSE_W-1:0]              thr_q;
   logic [CW-1:0]                 chan_q;
   logic [15:0]                   eval_q;
   logic                          dp_flush_q;
   logic                          meas_start_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          pass_q;

   logic [WL_W-1:0]               cur_frac;
   logic                          step_done;
   logic                          timer_load;
   logic                          timer_en;
   logic                          timer_zero;
   logic [TW-1:0]                 timer_val;

   assign cur_frac  = frac_q[chan_q];
   assign step_done = (cur_frac <= min_frac_q);

   // The timer is loaded with N-1 so that the zero flag marks the N-th cycle of the phase.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      timer_en   = 1'b0;
      case (state_q)
         STEP: begin
            if (!step_done) begin
               timer_load = 1'b1;
               timer_val  = TW'(FLUSH_CYC - 1);
            end
         end
         FLUSH: begin
            timer_en = 1'b1;
`ifdef WLO_TIMEOUT_EN
            if (timer_zero) begin
               timer_load = 1'b1;
               timer_val  = TW'(TIMEOUT_CYC - 1);
            end
`endif
         end
`ifdef WLO_TIMEOUT_EN
         MEASURE: timer_en = 1'b1;
`endif
         default: ;
      endcase
   end

   wlo_cycle_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .en_i       (timer_en),
      .zero_o     (timer_zero)
   );

`ifdef WLO_TIMEOUT_EN
   logic err_q;
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   // The accept/reject decision is registered while mse_data is valid, so DECIDE
   // does not depend on the collector holding its result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         frac_q       <= {NUM_CHAN{WL_W'(DEF_FRAC)}};
         min_frac_q   <= '0;
         thr_q        <= '0;
         chan_q       <= '0;
         eval_q       <= '0;
         dp_flush_q   <= 1'b0;
         meas_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
`ifdef WLO_TIMEOUT_EN
         err_q        <= 1'b0;
`endif
      end else begin
         meas_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go_i) begin
                  frac_q     <= {NUM_CHAN{init_frac_i}};
                  min_frac_q <= min_frac_i;
                  thr_q      <= mse_threshold_i;
                  chan_q     <= '0;
                  eval_q     <= '0;
                  busy_q     <= 1'b1;
`ifdef WLO_TIMEOUT_EN
                  err_q      <= 1'b0;
`endif
                  state_q    <= STEP;
               end
            end
            STEP: begin
               if (step_done) begin
                  state_q <= NEXT;
               end else begin
                  frac_q[chan_q] <= cur_frac - WL_W'(1);
                  dp_flush_q     <= 1'b1;
                  state_q        <= FLUSH;
               end
            end
            FLUSH: begin
               if (timer_zero) begin
                  dp_flush_q   <= 1'b0;
                  meas_start_q <= 1'b1;
                  state_q      <= MEASURE;
               end
            end
            MEASURE: begin
               if (mse_valid_i) begin
                  eval_q  <= sat_inc16(eval_q);
                  pass_q  <= (mse_data_i <= thr_q);
                  state_q <= DECIDE;
               end
`ifdef WLO_TIMEOUT_EN
               else if (timer_zero) begin
                  err_q          <= 1'b1;
                  frac_q[chan_q] <= cur_frac + WL_W'(1);
                  done_q         <= 1'b1;
                  busy_q         <= 1'b0;
                  state_q        <= DONE;
               end
`endif
            end
            DECIDE: begin
               if (pass_q) begin
                  state_q <= STEP;
               end else begin
                  frac_q[chan_q] <= cur_frac + WL_W'(1);
                  state_q        <= NEXT;
               end
            end
            NEXT: begin
               if (chan_q == CW'(NUM_CHAN - 1)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  chan_q  <= chan_q + CW'(1);
                  state_q <= STEP;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign frac_wl_o    = frac_q;
   assign dp_flush_o   = dp_flush_q;
   assign meas_start_o = meas_start_q;
   assign chan_idx_o   = chan_q;
   assign eval_count_o = eval_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_wlo_sweep_scheduler.sv
// Directed bench for wlo_sweep_scheduler with a behavioural MSE collector.
// The watchdog scenario is compiled in only when WLO_TIMEOUT_EN is defined.
module tb_wlo_sweep_scheduler;
   import wlo_pkg::*;

   localparam int NCH   = 15;
   localparam int FLUSH = 32;
   localparam int TOUT  = 100;
   // Collector MSE is expressed in units of 2^-8, so a threshold of 40 becomes 40*256.
   localparam logic [63:0] T40 = 64'd10240;
   localparam logic [7:0] EXP_A [NCH] = '{8'd10, 8'd10, 8'd11, 8'd12, 8'd12, 8'd12, 8'd13,
                                          8'd13, 8'd13, 8'd14, 8'd14, 8'd14, 8'd15, 8'd15, 8'd15};

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   go = 1'b0;
   logic [7:0]             initFrac = 8'd16;
   logic [7:0]             minFrac = 8'd4;
   logic [63:0]            mseThreshold = '0;
   logic [63:0]            mseData;
   logic                   mseValid;
   logic [63:0]            colData;
   logic                   colValid;
   logic                   strayValid = 1'b0;
   frac_vec_t              fracWl;
   logic                   dpFlush, measStart, busy, done, err;
   logic [$clog2(NCH)-1:0] chanIdx;
   logic [15:0]            evalCount;

   int compared = 0;
   int mismatched = 0;
   int silentChan = -1;
   int respDelay = 3;
   int cycleCnt = 0, measCount = 0, doneCount = 0, flushHigh = 0, flushRise = 0;
   int lastMs = 0, errRise = 0;
   logic flushPrev = 1'b0, errPrev = 1'b0;
   int m0, d0, fh0, fr0, cyc, gaps, wt;
   bit seen;

   assign mseValid = colValid | strayValid;
   assign mseData  = strayValid ? 64'd0 : colData;

   always #5 clk = ~clk;

   wlo_sweep_scheduler #(
      .NUM_CHAN    (NCH),
      .WL_W        (8),
      .FLUSH_CYC   (FLUSH),
      .MSE_W       (64),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .go_i            (go),
      .init_frac_i     (initFrac),
      .min_frac_i      (minFrac),
      .mse_threshold_i (mseThreshold),
      .mse_data_i      (mseData),
      .mse_valid_i     (mseValid),
      .frac_wl_o       (fracWl),
      .dp_flush_o      (dpFlush),
      .meas_start_o    (measStart),
      .chan_idx_o      (chanIdx),
      .eval_count_o    (evalCount),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err)
   );

   function automatic logic [63:0] mseModel(input frac_vec_t f);
      logic [63:0] s;
      s = '0;
      for (int i = 0; i < NCH; i++) begin
         if (f[i] <= 8'd16) s += 64'd1 << (2 * (16 - int'(f[i])));
      end
      return s;
   endfunction

   // Collector: answers each meas_start after respDelay cycles unless the channel is silenced.
   initial begin
      colValid = 1'b0;
      colData  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (measStart && (int'(chanIdx) != silentChan)) begin
            colData = mseModel(fracWl);
            repeat (respDelay) begin
               @(posedge clk);
               #1;
            end
            colValid = 1'b1;
            @(posedge clk);
            #1;
            colValid = 1'b0;
         end
      end
   end

   // Event counters sampled on the falling edge.
   always @(negedge clk) begin
      cycleCnt <= cycleCnt + 1;
      if (measStart) begin
         measCount <= measCount + 1;
         lastMs    <= cycleCnt;
      end
      if (done) doneCount <= doneCount + 1;
      if (dpFlush) flushHigh <= flushHigh + 1;
      if (dpFlush && !flushPrev) flushRise <= flushRise + 1;
      if (err && !errPrev) errRise <= cycleCnt;
      flushPrev <= dpFlush;
      errPrev   <= err;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] initV, input logic [7:0] minV, input logic [63:0] thrV);
      @(negedge clk);
      initFrac     = initV;
      minFrac      = minV;
      mseThreshold = thrV;
      go           = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int cycles, output int busyGaps, output bit gotDone);
      cycles   = 0;
      busyGaps = 0;
      gotDone  = 1'b0;
      while (!gotDone && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (done) gotDone = 1'b1;
         else if (!busy) busyGaps++;
      end
      #1;
   endtask

   task automatic snapshot();
      m0  = measCount;
      d0  = doneCount;
      fh0 = flushHigh;
      fr0 = flushRise;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_flush"}, 64'(dpFlush), 64'd0);
      checkOutput({tag, "_measStart"}, 64'(measStart), 64'd0);
      checkOutput({tag, "_chan"}, 64'(chanIdx), 64'd0);
      checkOutput({tag, "_eval"}, 64'(evalCount), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_err"}, 64'(err), 64'd0);
      checkOutput({tag, "_fracAll16"}, 64'(fracWl == {NCH{8'd16}}), 64'd1);
   endtask

   task automatic checkSweepA(input string tag);
      checkOutput({tag, "_doneSeen"}, 64'(seen), 64'd1);
      checkOutput({tag, "_busyGaps"}, 64'(gaps), 64'd0);
      checkOutput({tag, "_busyAfter"}, 64'(busy), 64'd0);
      checkOutput({tag, "_eval"}, 64'(evalCount), 64'd62);
      checkOutput({tag, "_measPulses"}, 64'(measCount - m0), 64'd62);
      for (int i = 0; i < NCH; i++) begin
         checkOutput($sformatf("%s_frac%0d", tag, i), 64'(fracWl[i]), 64'(EXP_A[i]));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      checkReset("reset");
      rst = 1'b0;

      $display("[TB] sweep with threshold 40, init 16, min 4");
      respDelay = 3;
      snapshot();
      applyStimulus(8'd16, 8'd4, T40);
      waitDone(6000, cyc, gaps, seen);
      repeat (3) @(negedge clk);
      #1;
      checkSweepA("sweepA");
      checkOutput("sweepA_donePulses", 64'(doneCount - d0), 64'd1);
      checkOutput("sweepA_err", 64'(err), 64'd0);

      $display("[TB] threshold 0, mse_valid together with meas_start");
      respDelay = 0;
      snapshot();
      applyStimulus(8'd16, 8'd4, 64'd0);
      waitDone(3000, cyc, gaps, seen);
      checkOutput("thr0_doneSeen", 64'(seen), 64'd1);
      checkOutput("thr0_eval", 64'(evalCount), 64'd15);
      checkOutput("thr0_fracAll16", 64'(fracWl == {NCH{8'd16}}), 64'd1);
      checkOutput("thr0_flushCycles", 64'(flushHigh - fh0), 64'(15 * FLUSH));
      checkOutput("thr0_flushPulses", 64'(flushRise - fr0), 64'd15);
      checkOutput("thr0_measPulses", 64'(measCount - m0), 64'd15);

      $display("[TB] init equal to min");
      respDelay = 3;
      snapshot();
      applyStimulus(8'd6, 8'd6, T40);
      waitDone(100, cyc, gaps, seen);
      checkOutput("initMin_doneSeen", 64'(seen), 64'd1);
      checkOutput("initMin_doneCycle", 64'(cyc), 64'(2 * NCH + 1));
      checkOutput("initMin_eval", 64'(evalCount), 64'd0);
      checkOutput("initMin_measPulses", 64'(measCount - m0), 64'd0);
      checkOutput("initMin_frac14", 64'(fracWl[14]), 64'd6);

      $display("[TB] init below min, then stray mse_valid while idle");
      applyStimulus(8'd3, 8'd6, T40);
      waitDone(100, cyc, gaps, seen);
      checkOutput("initBelow_frac0", 64'(fracWl[0]), 64'd3);
      @(negedge clk);
      strayValid = 1'b1;
      @(negedge clk);
      strayValid = 1'b0;
      #1;
      checkOutput("idleStray_eval", 64'(evalCount), 64'd0);

      $display("[TB] sweep with go during MEASURE and stray mse_valid during FLUSH");
      snapshot();
      applyStimulus(8'd16, 8'd4, T40);
      fork
         waitDone(6000, cyc, gaps, seen);
         begin : disturb
            int w;
            for (int k = 0; k < 3; k++) begin
               w = 0;
               while (!dpFlush && w < 200) begin
                  @(negedge clk);
                  w++;
               end
               repeat (5) @(negedge clk);
               strayValid = 1'b1;
               @(negedge clk);
               strayValid = 1'b0;
               w = 0;
               while (!measStart && w < 200) begin
                  @(negedge clk);
                  w++;
               end
               go       = 1'b1;
               initFrac = 8'd3;
               @(negedge clk);
               go       = 1'b0;
               initFrac = 8'd16;
               repeat (3) @(negedge clk);
            end
         end
      join
      repeat (3) @(negedge clk);
      #1;
      checkSweepA("disturbed");
      checkOutput("disturbed_donePulses", 64'(doneCount - d0), 64'd1);

      $display("[TB] reset during FLUSH of channel 7");
      applyStimulus(8'd16, 8'd4, T40);
      wt = 0;
      while (!(chanIdx == 4'd7 && dpFlush) && wt < 6000) begin
         @(negedge clk);
         wt++;
      end
      checkOutput("midReset_reachedCh7Flush", 64'(chanIdx == 4'd7 && dpFlush), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkReset("midReset");
      @(negedge clk);
      rst = 1'b0;
      snapshot();
      applyStimulus(8'd16, 8'd4, T40);
      waitDone(6000, cyc, gaps, seen);
      repeat (3) @(negedge clk);
      #1;
      checkSweepA("afterReset");

`ifdef WLO_TIMEOUT_EN
      $display("[TB] collector silent on channel 3");
      silentChan = 3;
      snapshot();
      applyStimulus(8'd16, 8'd4, T40);
      waitDone(6000, cyc, gaps, seen);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("timeout_doneSeen", 64'(seen), 64'd1);
      checkOutput("timeout_err", 64'(err), 64'd1);
      checkOutput("timeout_errLatency", 64'(errRise - lastMs), 64'(TOUT));
      checkOutput("timeout_frac3", 64'(fracWl[3]), 64'd16);
      checkOutput("timeout_frac2", 64'(fracWl[2]), 64'd11);
      checkOutput("timeout_eval", 64'(evalCount), 64'd20);
      checkOutput("timeout_donePulses", 64'(doneCount - d0), 64'd1);
      silentChan = -1;
      snapshot();
      applyStimulus(8'd16, 8'd4, T40);
      checkOutput("timeout_errClearedByGo", 64'(err), 64'd0);
      waitDone(6000, cyc, gaps, seen);
      repeat (3) @(negedge clk);
      #1;
      checkSweepA("timeoutRecovery");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
